vga_pixel_fetch: RTL and testbench

//   Parametrised pixel-fetch pipeline for the VGA subsystem: selects the topmost active layer per pixel,

---
 rtl/vga_pixel_fetch.sv | 206 ++++++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: top-layer select, skid-buffered cache fetch, pixel FIFO.
// Build option: VGA_FETCH_STATS_EN enables the underflow_count statistic.
//
// Ports:
//   clock, reset            clock; async active-high reset
//   new_frame, next_pixel   frame start (flush) / new fetch position
//   mode_16bpp              pixel format, latched on new_frame
//   layer_address/_active   per-layer byte address and hit flags
//   fetch_stall             back-pressure to the pixel counter
//   cache_*                 request (valid/ready) and read-return channel
//   pixel_read/_data/_valid FIFO head towards the palette stage
//   underflow(_count)       read-while-empty pulse and its counter
`timescale 1ns/1ps
module vga_pixel_fetch #(
  parameter int NUM_LAYERS   = 8,
  parameter int ADDR_W       = 26,
  parameter int FIFO_DEPTH   = 512,
  parameter int STALL_MARGIN = 10,
  parameter int MAX_OUTSTAND = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         new_frame,
  input  logic                         next_pixel,
  input  logic                         mode_16bpp,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_address,
  input  logic [NUM_LAYERS-1:0]        layer_active,
  output logic                         fetch_stall,
  output logic                         cache_request,
  input  logic                         cache_ready,
  output logic [ADDR_W-1:0]            cache_address,
  input  logic                         cache_rvalid,
  input  logic [31:0]                  cache_rdata,
  input  logic [ADDR_W-1:0]            cache_raddress,
  input  logic                         pixel_read,
  output logic [15:0]                  pixel_data,
  output logic                         pixel_valid,
  output logic                         underflow,
  output logic [15:0]                  underflow_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTAND + 1);
  localparam logic [31:0] DEPTH_L  = 32'(FIFO_DEPTH);
  localparam logic [31:0] MARGIN_L = 32'(STALL_MARGIN);

  logic                         in_frame;
  logic                         mode16;

  logic                         s1_valid;
  logic [NUM_LAYERS*ADDR_W-1:0] s1_addr;
  logic [NUM_LAYERS-1:1]        s1_active;
  logic                         s2_valid;
  logic [ADDR_W-1:0]            s2_addr;

  logic [ADDR_W-1:0]            sk_mem [2];
  logic                         sk_head;
  logic [1:0]                   sk_cnt;

  logic [OW-1:0]                outstanding;
  logic [OW-1:0]                discard;
  logic [OW-1:0]                out_next;

  logic [15:0]                  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]                wptr;
  logic [PW-1:0]                rptr;
  logic [CW-1:0]                count;

  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        byte_sel;
  logic [15:0]       pix;
  logic sk_any, req_ok, xfer, pop, direct;
  logic s2_take, push, s2_adv, s1_adv, np_ok;
  logic tail, dec, acc, fwr, frd;

  logic unused_in;
  assign unused_in = ^{cache_raddress[ADDR_W-1:2], layer_active[0]};

  // Later layers overwrite earlier ones: highest active index wins.
  always_comb begin
    sel_addr = s1_addr[ADDR_W-1:0];
    for (int i = 1; i < NUM_LAYERS; i++)
      if (s1_active[i]) sel_addr = s1_addr[i*ADDR_W +: ADDR_W];
    if (mode16) sel_addr[0] = 1'b0;
  end

  // Skid head falls through to stage 2 when empty (no bubble).
  assign sk_any        = sk_cnt != 2'd0;
  assign req_ok        = outstanding < OW'(MAX_OUTSTAND);
  assign cache_request = (sk_any | s2_valid) & req_ok;
  assign cache_address = sk_any ? sk_mem[sk_head] : s2_addr;
  assign xfer          = cache_request & cache_ready;
  assign pop           = xfer & sk_any;
  assign direct        = xfer & ~sk_any;
  assign s2_take = s2_valid & ((sk_cnt != 2'd2) | pop);
  assign push    = s2_take & ~direct;
  assign s2_adv  = ~s2_valid | s2_take;
  assign s1_adv  = ~s1_valid | s2_adv;
  assign np_ok   = next_pixel & in_frame & ~new_frame;
  // With two slots, the free slot is head^cnt[0] in every push case.
  assign tail    = sk_head ^ sk_cnt[0];

  // Late returns with nothing outstanding are ignored entirely.
  assign dec      = cache_rvalid & (outstanding != '0);
  assign out_next = outstanding + OW'(xfer) - OW'(dec);
  assign acc      = dec & (discard == '0);

  always_comb begin
    unique case (cache_raddress[1:0])
      2'd0: byte_sel = cache_rdata[7:0];
      2'd1: byte_sel = cache_rdata[15:8];
      2'd2: byte_sel = cache_rdata[23:16];
      2'd3: byte_sel = cache_rdata[31:24];
    endcase
    if (mode16)
      pix = cache_raddress[1] ? cache_rdata[31:16]
                              : cache_rdata[15:0];
    else
      pix = {8'h00, byte_sel};
  end

  assign pixel_valid = count != '0;
  assign pixel_data  = pixel_valid ? fifo_mem[rptr] : 16'h0;
  assign frd = pixel_read & pixel_valid;
  assign fwr = acc & ((count != CW'(FIFO_DEPTH)) | frd);

  // Stall on free slots minus in-flight data, rearranged unsigned.
  assign fetch_stall =
    (32'(count) + 32'(outstanding) + MARGIN_L) > DEPTH_L;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_frame    <= 1'b0;
      mode16      <= 1'b0;
      s1_valid    <= 1'b0;
      s1_addr     <= '0;
      s1_active   <= '0;
      s2_valid    <= 1'b0;
      s2_addr     <= '0;
      sk_mem[0]   <= '0;
      sk_mem[1]   <= '0;
      sk_head     <= 1'b0;
      sk_cnt      <= 2'd0;
      outstanding <= '0;
      discard     <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      underflow   <= 1'b0;
    end else begin
      underflow   <= pixel_read & ~pixel_valid;
      outstanding <= out_next;
      if (new_frame) begin
        in_frame <= 1'b1;
        mode16   <= mode_16bpp;
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
        sk_head  <= 1'b0;
        sk_cnt   <= 2'd0;
        discard  <= out_next;
        wptr     <= '0;
        rptr     <= '0;
        count    <= '0;
      end else begin
        if (s1_adv) begin
          s1_valid  <= np_ok;
          s1_addr   <= layer_address;
          s1_active <= layer_active[NUM_LAYERS-1:1];
        end
        if (s2_adv) begin
          s2_valid <= s1_valid;
          s2_addr  <= sel_addr;
        end
        if (push) sk_mem[tail] <= s2_addr;
        if (pop) sk_head <= ~sk_head;
        sk_cnt <= sk_cnt + {1'b0, push} - {1'b0, pop};
        if (cache_rvalid && discard != '0)
          discard <= discard - 1'b1;
        if (fwr) wptr <= wptr + 1'b1;
        if (frd) rptr <= rptr + 1'b1;
        count <= count + CW'(fwr) - CW'(frd);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (fwr && !new_frame) fifo_mem[wptr] <= pix;
  end

`ifdef VGA_FETCH_STATS_EN
  logic [15:0] uf_cnt;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      uf_cnt <= 16'h0;
    else if (new_frame)
      uf_cnt <= {15'h0, underflow};
    else if (underflow && uf_cnt != 16'hFFFF)
      uf_cnt <= uf_cnt + 16'h1;
  end
  assign underflow_count = uf_cnt;
`else
  assign underflow_count = 16'h0;
`endif

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: directed + randomized bench for vga_pixel_fetch.
// Queue-level reference model of requests, in-flight data and FIFO.
`timescale 1ns/1ps
module tb_vga_pixel_fetch;
  localparam int NL    = 8;
  localparam int AW    = 26;
  localparam int DEPTH = 512;
  localparam int MARG  = 10;
  localparam int MAXO  = 16;
`ifdef VGA_FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clock = 0, reset = 0;
  logic new_frame = 0, next_pixel = 0, mode_16bpp = 0;
  logic [NL*AW-1:0] layer_address = '0;
  logic [NL-1:0] layer_active = '0;
  logic fetch_stall, cache_request;
  logic cache_ready = 0;
  logic [AW-1:0] cache_address;
  logic cache_rvalid = 0;
  logic [31:0] cache_rdata = '0;
  logic [AW-1:0] cache_raddress = '0;
  logic pixel_read = 0;
  logic [15:0] pixel_data, underflow_count;
  logic pixel_valid, underflow;

  always #4 clock = ~clock;

  vga_pixel_fetch dut (
    .clock(clock), .reset(reset),
    .new_frame(new_frame), .next_pixel(next_pixel),
    .mode_16bpp(mode_16bpp),
    .layer_address(layer_address),
    .layer_active(layer_active),
    .fetch_stall(fetch_stall),
    .cache_request(cache_request),
    .cache_ready(cache_ready),
    .cache_address(cache_address),
    .cache_rvalid(cache_rvalid),
    .cache_rdata(cache_rdata),
    .cache_raddress(cache_raddress),
    .pixel_read(pixel_read), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .underflow(underflow),
    .underflow_count(underflow_count)
  );

  int checks = 0, errors = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] fly_q[$];
  logic [15:0] pix_q[$];
  int mo = 0, disc = 0, ucnt = 0;
  bit mif = 0, mmode = 0, uf_exp = 0;
  logic [15:0] t1e [4] = '{16'h11, 16'h22, 16'h33, 16'h44};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] top_addr(
      input logic [NL-1:0] act, input logic [NL*AW-1:0] a,
      input bit m);
    logic [AW-1:0] r;
    int w;
    w = 0;
    for (int i = NL - 1; i >= 1; i--)
      if (act[i]) begin w = i; break; end
    r = a[w*AW +: AW];
    if (m) r[0] = 1'b0;
    return r;
  endfunction

  function automatic logic [15:0] pix_of(
      input logic [31:0] d, input logic [AW-1:0] ra, input bit m);
    logic [31:0] s;
    if (m) return ra[1] ? d[31:16] : d[15:0];
    s = d >> (8 * int'(ra[1:0]));
    return {8'h00, s[7:0]};
  endfunction

  task automatic step(input int n);
    bit uf_n;
    repeat (n) begin
      chk("pixel_valid", 32'(pixel_valid), 32'(pix_q.size() != 0));
      chk("pixel_data", 32'(pixel_data),
          pix_q.size() != 0 ? 32'(pix_q[0]) : 32'h0);
      chk("fetch_stall", 32'(fetch_stall),
          32'((DEPTH - pix_q.size() - mo) < MARG));
      chk("underflow", 32'(underflow), 32'(uf_exp));
      chk("underflow_count", 32'(underflow_count),
          STATS ? 32'(ucnt) : 32'h0);
      if (mo >= MAXO) chk("req_gate", 32'(cache_request), 0);
      if (cache_request && cache_ready) begin
        chk("req_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          chk("cache_address", 32'(cache_address),
              32'(exp_q.pop_front()));
        fly_q.push_back(cache_address);
        mo++;
      end
      uf_n = pixel_read && pix_q.size() == 0;
      if (pixel_read && pix_q.size() != 0) void'(pix_q.pop_front());
      if (cache_rvalid && mo > 0) begin
        mo--;
        if (disc > 0) disc--;
        else if (pix_q.size() < DEPTH)
          pix_q.push_back(pix_of(cache_rdata, cache_raddress, mmode));
      end
      if (next_pixel && mif && !new_frame)
        exp_q.push_back(top_addr(layer_active, layer_address, mmode));
      if (new_frame) begin
        ucnt = uf_exp ? 1 : 0;
        pix_q.delete();
        exp_q.delete();
        disc = mo;
        mif = 1;
        mmode = mode_16bpp;
      end else if (uf_exp && ucnt < 65535) ucnt++;
      uf_exp = uf_n;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic hard_reset();
    reset = 1;
    #1;
    mo = 0; disc = 0; ucnt = 0;
    mif = 0; mmode = 0; uf_exp = 0;
    exp_q.delete();
    pix_q.delete();
    chk("rst_req", 32'(cache_request), 0);
    chk("rst_addr", 32'(cache_address), 0);
    chk("rst_valid", 32'(pixel_valid), 0);
    chk("rst_data", 32'(pixel_data), 0);
    chk("rst_uf", 32'(underflow), 0);
    chk("rst_stall", 32'(fetch_stall), 0);
    chk("rst_ucnt", 32'(underflow_count), 0);
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  task automatic nf(input bit m);
    mode_16bpp = m;
    new_frame = 1;
    step(1);
    new_frame = 0;
  endtask

  task automatic pulse();
    next_pixel = 1;
    step(1);
    next_pixel = 0;
  endtask

  task automatic rnd_layers();
    for (int i = 0; i < NL; i++)
      layer_address[i*AW +: AW] = AW'($urandom);
    layer_active = NL'($urandom);
  endtask

  task automatic resp_all(input logic [31:0] d, input bit rnd);
    for (int i = 0; i < 64 && fly_q.size() != 0; i++) begin
      cache_rvalid = 1;
      cache_raddress = fly_q.pop_front();
      cache_rdata = rnd ? $urandom : d;
      step(1);
    end
    cache_rvalid = 0;
  endtask

  task automatic drain();
    pixel_read = 1;
    for (int i = 0; i < 600 && pix_q.size() != 0; i++) step(1);
    pixel_read = 0;
    step(1);
  endtask

  initial begin
    #1 hard_reset();

    // next_pixel before the first frame is ignored
    layer_address[AW-1:0] = AW'(32'h55);
    pulse();
    step(4);
    chk("pre_frame_req", 32'(cache_request), 0);

    // 8bpp byte lanes from one word
    cache_ready = 1;
    nf(0);
    for (int i = 0; i < 4; i++) begin
      layer_address[AW-1:0] = AW'(32'h100 + i);
      pulse();
    end
    step(4);
    chk("t1_issued", 32'(exp_q.size()), 0);
    resp_all(32'h44332211, 0);
    pixel_read = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t1_pix", 32'(pixel_data), 32'(t1e[i]));
      step(1);
    end
    pixel_read = 0;
    step(1);

    // topmost layer, two-cycle latency
    cache_ready = 0;
    for (int i = 0; i < NL; i++)
      layer_address[i*AW +: AW] = AW'(32'h1000 + i * 16);
    layer_active = 8'b1010_0110;
    pulse();
    chk("lat1_req", 32'(cache_request), 0);
    step(1);
    chk("lat2_req", 32'(cache_request), 1);
    chk("lat2_addr", 32'(cache_address), 32'h1070);
    cache_ready = 1;
    step(2);
    resp_all(0, 1);
    drain();

    // ready held low: address stable, nothing lost
    cache_ready = 0;
    rnd_layers();
    pulse();
    step(1);
    for (int i = 0; i < 18; i++) begin
      chk("hold_req", 32'(cache_request), 1);
      chk("hold_addr", 32'(cache_address), 32'(exp_q[0]));
      if (i == 2 || i == 5) rnd_layers();
      next_pixel = (i == 2 || i == 5);
      step(1);
    end
    next_pixel = 0;
    chk("hold_pend", 32'(exp_q.size()), 3);
    cache_ready = 1;
    step(6);
    chk("hold_done", 32'(exp_q.size()), 0);
    resp_all(0, 1);
    drain();

    // 16bpp halfword
    nf(1);
    layer_active = '0;
    layer_address[AW-1:0] = AW'(32'h203);
    pulse();
    step(4);
    chk("t4_addr", 32'(fly_q[0]), 32'h202);
    resp_all(32'hBEEFCAFE, 0);
    chk("t4_pix", 32'(pixel_data), 32'hBEEF);
    drain();

    // new_frame discards in-flight returns
    nf(0);
    for (int i = 0; i < 5; i++) begin
      rnd_layers();
      pulse();
    end
    step(4);
    chk("t5_flight", 32'(fly_q.size()), 5);
    nf(0);
    resp_all(0, 1);
    chk("t5_empty", 32'(pixel_valid), 0);
    layer_active = '0;
    layer_address[AW-1:0] = AW'(32'h302);
    pulse();
    step(4);
    resp_all(32'hA1B2C3D4, 0);
    chk("t5_next", 32'(pixel_data), 32'hB2);
    drain();

    // fill FIFO until fetch_stall rises
    chk("fill_stall0", 32'(fetch_stall), 0);
    for (int b = 0; b < 70 && pix_q.size() < 500; b++) begin
      for (int k = 0; k < 8; k++) begin
        rnd_layers();
        pulse();
        step(1);
      end
      step(3);
      resp_all(0, 1);
    end
    chk("fill_stall1", 32'(fetch_stall), 1);
    drain();
    chk("drained", 32'(pixel_valid), 0);

    // randomized traffic with a mid-run new_frame
    for (int c = 0; c < 400; c++) begin
      rnd_layers();
      next_pixel = (exp_q.size() < 3) && ($urandom_range(2) == 0);
      cache_ready = $urandom_range(3) != 0;
      pixel_read = $urandom_range(2) == 0;
      new_frame = (c == 200);
      if (c == 200) mode_16bpp = 1'($urandom_range(1));
      cache_rvalid = 0;
      if (fly_q.size() != 0 && $urandom_range(1) == 1) begin
        cache_rvalid = 1;
        cache_raddress = fly_q.pop_front();
        cache_rdata = $urandom;
      end
      step(1);
    end
    new_frame = 0;
    next_pixel = 0;
    cache_rvalid = 0;
    pixel_read = 0;
    cache_ready = 1;
    step(8);
    resp_all(0, 1);
    drain();

    // underflow pulses and counter
    nf(0);
    pixel_read = 1;
    step(3);
    pixel_read = 0;
    step(3);
    chk("ucount3", 32'(underflow_count), STATS ? 32'd3 : 32'd0);
    nf(0);
    step(1);
    chk("ucount_clr", 32'(underflow_count), 0);

    // reset mid-burst, late returns ignored
    for (int i = 0; i < 3; i++) begin
      rnd_layers();
      pulse();
    end
    step(4);
    hard_reset();
    resp_all(0, 1);
    step(2);
    chk("late_rvalid", 32'(pixel_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
